// File: rtl/reg_a_uart_monitor_pkg.sv
// Shared constants, state encodings and the hex-to-ASCII helper for the
// reg_a UART monitor.
package reg_a_uart_monitor_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 104;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    typedef enum logic [2:0] {
        MSG_IDLE,
        MSG_SEND_HI,
        MSG_SEND_LO,
        MSG_SEND_CR,
        MSG_SEND_LF
    } msg_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_ZERO + {4'd0, nib};
        end
        return ASCII_A + {4'd0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/reg_a_uart_monitor_uart_tx_byte.sv
// 8N1 byte serializer. done is asserted combinationally in the last cycle of
// the stop bit; a start seen in that same cycle chains straight into the next
// start bit, so consecutive bytes have no idle gap.
//
// state    | meaning
// TX_IDLE  | line high, waiting for start
// TX_START | start bit (0)
// TX_DATA  | 8 data bits, LSB first
// TX_STOP  | stop bit (1)
module uart_tx_byte
    import reg_a_uart_monitor_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       CLK,
    input  logic       R,
    input  logic       start,
    input  logic [7:0] data,
    output logic       done,
    output logic       idle,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [7:0]    sh, sh_nxt;
    logic          tx_nxt;

    assign idle = (state == TX_IDLE);

    // Register serializer state; reset drives the line high immediately.
    always_ff @(posedge CLK) begin
        if (!R) begin
            state <= TX_IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            tx    <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            sh    <= sh_nxt;
            tx    <= tx_nxt;
        end
    end

    // Bit timing down-counter and bit sequencing.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        sh_nxt    = sh;
        tx_nxt    = tx;
        done      = 1'b0;
        case (state)
            TX_IDLE: begin
                tx_nxt = 1'b1;
                if (start) begin
                    state_nxt = TX_START;
                    sh_nxt    = data;
                    cnt_nxt   = LAST;
                    tx_nxt    = 1'b0;
                end
            end
            TX_START: begin
                if (cnt == '0) begin
                    state_nxt = TX_DATA;
                    cnt_nxt   = LAST;
                    idx_nxt   = 3'd0;
                    tx_nxt    = sh[0];
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            TX_DATA: begin
                if (cnt == '0) begin
                    cnt_nxt = LAST;
                    if (idx == 3'd7) begin
                        state_nxt = TX_STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        idx_nxt = idx + 3'd1;
                        sh_nxt  = {1'b0, sh[7:1]};
                        tx_nxt  = sh[1];
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            TX_STOP: begin
                if (cnt == '0) begin
                    done = 1'b1;
                    if (start) begin
                        state_nxt = TX_START;
                        sh_nxt    = data;
                        cnt_nxt   = LAST;
                        tx_nxt    = 1'b0;
                    end else begin
                        state_nxt = TX_IDLE;
                        tx_nxt    = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = TX_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/reg_a_uart_monitor.sv
// Watches the CPU accumulator and prints every new value as "HH\r\n" on a
// UART line. A single pending slot holds the newest unsent value.
//
// state       | meaning
// MSG_IDLE    | no message in flight; loads pending when full
// MSG_SEND_HI | sending upper-nibble hex digit
// MSG_SEND_LO | sending lower-nibble hex digit
// MSG_SEND_CR | sending carriage return
// MSG_SEND_LF | sending line feed
module reg_a_uart_monitor
    import reg_a_uart_monitor_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       CLK,
    input  logic       R,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       tx,
    output logic       busy,
    output logic       dropped
);

    msg_state_t state, state_nxt;
    logic [7:0] msg_val, pend_val, last_val;
    logic       pend_full, last_valid;
    logic       accept, consume, drop, busy_nxt;
    logic       tx_start, tx_done, tx_idle;
    logic [7:0] tx_byte;

    // Message state register.
    always_ff @(posedge CLK) begin
        if (!R) begin
            state <= MSG_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Advance one character each time the serializer finishes a stop bit.
    always_comb begin
        state_nxt = state;
        case (state)
            MSG_IDLE:    if (pend_full) state_nxt = MSG_SEND_HI;
            MSG_SEND_HI: if (tx_done)   state_nxt = MSG_SEND_LO;
            MSG_SEND_LO: if (tx_done)   state_nxt = MSG_SEND_CR;
            MSG_SEND_CR: if (tx_done)   state_nxt = MSG_SEND_LF;
            MSG_SEND_LF: if (tx_done)   state_nxt = MSG_IDLE;
            default:                    state_nxt = MSG_IDLE;
        endcase
    end

    // Change detection, pending-slot bookkeeping and serializer handshake.
    // The byte offered is the one for the state being entered, so a chained
    // start at done already carries the next character.
    always_comb begin
        accept   = data_valid && (!last_valid || (data_in != last_val));
        consume  = (state == MSG_IDLE) && pend_full;
        drop     = accept && pend_full && !consume;
        busy_nxt = (state_nxt != MSG_IDLE) || accept || (pend_full && !consume);
        tx_start = (state != MSG_IDLE) && (state_nxt != MSG_IDLE) && (tx_idle || tx_done);
        tx_byte  = ASCII_LF;
        case (state_nxt)
            MSG_SEND_HI: tx_byte = hex_ascii(msg_val[7:4]);
            MSG_SEND_LO: tx_byte = hex_ascii(msg_val[3:0]);
            MSG_SEND_CR: tx_byte = ASCII_CR;
            default:     tx_byte = ASCII_LF;
        endcase
    end

    // Pending slot, last-accepted value and registered status outputs.
    always_ff @(posedge CLK) begin
        if (!R) begin
            msg_val    <= '0;
            pend_val   <= '0;
            pend_full  <= 1'b0;
            last_val   <= '0;
            last_valid <= 1'b0;
            busy       <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            if (consume) begin
                msg_val <= pend_val;
            end
            if (accept) begin
                pend_val   <= data_in;
                pend_full  <= 1'b1;
                last_val   <= data_in;
                last_valid <= 1'b1;
            end else if (consume) begin
                pend_full <= 1'b0;
            end
            busy    <= busy_nxt;
            dropped <= drop;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .CLK   (CLK),
        .R     (R),
        .start (tx_start),
        .data  (tx_byte),
        .done  (tx_done),
        .idle  (tx_idle),
        .tx    (tx)
    );

endmodule

// File: tb/tb_reg_a_uart_monitor.sv
// Bench for reg_a_uart_monitor with CLKS_PER_BIT=4: fixed vectors, directed
// sequences and random strobes against a message-level reference model; the
// tx line is decoded by an independent UART receiver.
module tb_reg_a_uart_monitor;

    localparam int CPB = 4;
    localparam int MSG = 40 * CPB;

    logic       CLK;
    logic       R;
    logic [7:0] data_in;
    logic       data_valid;
    logic       tx;
    logic       busy;
    logic       dropped;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    reg_a_uart_monitor #(.CLKS_PER_BIT(CPB)) dut (
        .CLK        (CLK),
        .R          (R),
        .data_in    (data_in),
        .data_valid (data_valid),
        .tx         (tx),
        .busy       (busy),
        .dropped    (dropped)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // ---------------- receiver (decodes tx, mid-bit sampling) ----------------
    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         rx_ferr = 0;

    initial begin
        bit         act;
        int         c;
        int         k;
        int         t0;
        logic [7:0] sh;
        act = 0; c = 0; t0 = 0; sh = '0;
        forever begin
            @(negedge CLK);
            if (!R) begin
                act = 0;
                while ((rx_q.size() % 4) != 0) begin
                    void'(rx_q.pop_back());
                    void'(rx_t.pop_back());
                end
            end else if (act) begin
                c++;
                if ((c % CPB) == CPB / 2) begin
                    k = c / CPB;
                    if (k == 0 && tx !== 1'b0) rx_ferr++;
                    if (k >= 1 && k <= 8) sh[k-1] = tx;
                    if (k == 9) begin
                        if (tx !== 1'b1) rx_ferr++;
                        rx_q.push_back(sh);
                        rx_t.push_back(t0);
                        act = 0;
                    end
                end
            end else if (tx === 1'b0) begin
                act = 1; c = 0; t0 = cyc;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];
    int         exp_t[$];
    int         m_busy_until = -1;
    logic [7:0] m_pend = '0, m_last = '0;
    bit         m_pend_v = 0, m_last_v = 0;
    bit         m_busy, m_drop, m_txfree;

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
    endfunction

    // Apply one clock of stimulus, predict, then compare after the edge.
    task automatic cycle(input logic r, input logic dv, input logic [7:0] d);
        int e;
        bit acc, cons;
        e = cyc + 1;
        R = r; data_valid = dv; data_in = d;
        m_drop = 0;
        if (!r) begin
            if (e <= m_busy_until && exp_t.size() > 0) begin
                for (int i = 0; i < 4; i++) void'(exp_q.pop_back());
                void'(exp_t.pop_back());
            end
            m_busy_until = -1;
            m_pend_v = 0;
            m_last_v = 0;
        end else begin
            cons = (e > m_busy_until) && m_pend_v;
            if (cons) begin
                exp_q.push_back(hexc(m_pend[7:4]));
                exp_q.push_back(hexc(m_pend[3:0]));
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
                exp_t.push_back(e + 1);
                m_busy_until = e + 1 + MSG;
            end
            acc = dv && (!m_last_v || d != m_last);
            m_drop = acc && m_pend_v && !cons;
            if (acc) begin
                m_pend = d; m_pend_v = 1; m_last = d; m_last_v = 1;
            end else if (cons) begin
                m_pend_v = 0;
            end
        end
        m_busy   = (e < m_busy_until) || m_pend_v;
        m_txfree = !(e >= m_busy_until - MSG && e < m_busy_until);
        @(negedge CLK);
        chk("busy", int'(busy), int'(m_busy));
        chk("dropped", int'(dropped), int'(m_drop));
        if (m_txfree) chk("tx_idle_high", int'(tx), 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00);
    endtask

    task automatic expect_last(input string name, input string s);
        int n;
        int base;
        n = s.len();
        chk({name, "_len"}, int'(rx_q.size() >= n), 1);
        if (rx_q.size() >= n) begin
            base = rx_q.size() - n;
            for (int i = 0; i < n; i++) chk(name, int'(rx_q[base+i]), int'(s[i]));
        end
    endtask

    typedef struct {
        logic       r;
        logic       dv;
        logic [7:0] d;
        logic       tx;
        logic       busy;
        logic       drop;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int         n0;
        logic [7:0] rd;
        R = 1'b0; data_valid = 1'b0; data_in = 8'h00;

        // reset hold, sample ignored in reset, then 0x3C start-bit timing
        vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].r, vecs[i].dv, vecs[i].d);
            chk("vec_tx", int'(tx), int'(vecs[i].tx));
            chk("vec_busy", int'(busy), int'(vecs[i].busy));
            chk("vec_dropped", int'(dropped), int'(vecs[i].drop));
        end
        idle(170);
        expect_last("basic_3C", "3C\r\n");
        chk("basic_busy_done", int'(busy), 0);

        // unchanged value is not resent
        n0 = rx_q.size();
        cycle(1'b1, 1'b1, 8'h3C);
        chk("repeat_busy", int'(busy), 0);
        idle(50);
        chk("repeat_no_bytes", rx_q.size(), n0);

        // overwrite: 02 replaced by 03 while 01 is in flight
        cycle(1'b1, 1'b1, 8'h01);
        idle(20);
        cycle(1'b1, 1'b1, 8'h02);
        chk("ovw_no_drop_02", int'(dropped), 0);
        idle(5);
        cycle(1'b1, 1'b1, 8'h03);
        chk("ovw_drop_03", int'(dropped), 1);
        idle(400);
        expect_last("ovw", "01\r\n03\r\n");

        // reset during the low-nibble data bits
        cycle(1'b1, 1'b1, 8'h5A);
        idle(55);
        cycle(1'b0, 1'b0, 8'h00);
        chk("rst_mid_tx", int'(tx), 1);
        chk("rst_mid_busy", int'(busy), 0);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'h3C);
        idle(200);
        expect_last("after_rst", "3C\r\n");

        // boundary values, second arriving during the first message
        cycle(1'b1, 1'b1, 8'h00);
        idle(30);
        cycle(1'b1, 1'b1, 8'hFF);
        idle(400);
        expect_last("bounds", "00\r\nFF\r\n");

        // random strobes from a small value set to exercise repeats and drops
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 5))
                0: rd = 8'h00;
                1: rd = 8'hFF;
                2: rd = 8'h3C;
                3: rd = 8'hA5;
                4: rd = 8'h5A;
                default: rd = 8'($urandom_range(0, 255));
            endcase
            cycle(1'b1, ($urandom_range(0, 29) == 0), rd);
        end
        idle(400);

        // full stream, per-message start time and back-to-back bytes
        chk("rx_framing", rx_ferr, 0);
        chk("rx_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            chk("rx_byte", int'(rx_q[i]), int'(exp_q[i]));
        for (int m = 0; m < exp_t.size() && 4 * m + 3 < rx_t.size(); m++) begin
            chk("msg_start", rx_t[4*m], exp_t[m]);
            for (int b = 1; b < 4; b++)
                chk("byte_gap", rx_t[4*m+b] - rx_t[4*m+b-1], 10 * CPB);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
